ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard on the shared
// ps2c/ps2d open-collector lines; the reverse direction of the existing keyboard receive path. Drives lines only via
// active-low output enables (pad: line = oe ? 0 : Z). tx_idle gates the keyboard receiver while a frame is in flight.
// PARAMETERS
// INHIBIT_CYCLES  12000      clk cycles ps2c is held low for request-to-send (120 us at 100 MHz)
// FILTER_LEN      8          ps2c glitch filter depth; filtered level changes only after FILTER_LEN equal samples
// TIMEOUT_CYCLES  2000000    watchdog limit between device clock edges (only with PS2_TX_TIMEOUT_EN)
// PORTS
// clk           in   1  system clock
// rst           in   1  asynchronous reset, active-low
// wr_ps2        in   1  1-cycle start strobe; accepted only when tx_idle=1
// din           in   8  command byte, sampled on accepted wr_ps2
// ps2c_in       in   1  ps2c pad level (async; 2-FF synchronised internally)
// ps2d_in       in   1  ps2d pad level (async; 2-FF synchronised internally)
// ps2c_oe       out  1  1 = pull ps2c low
// ps2d_oe       out  1  1 = pull ps2d low
// tx_idle       out  1  1 = IDLE state, lines released
// tx_done_tick  out  1  1-cycle pulse at frame end (ack, nack or timeout)
// ack_err       out  1  sticky: last frame got no device ack (or timed out); cleared on next accepted wr_ps2
// BEHAVIOUR
// - Reset (rst=0): state IDLE, ps2c_oe=0, ps2d_oe=0, tx_idle=1, tx_done_tick=0, ack_err=0, counters/shift reg 0. Reset
//   mid-frame releases both lines immediately (async); no done tick.
// - Input conditioning: ps2c/ps2d 2-FF synced; ps2c through FILTER_LEN shift reg; fall = filtered 1->0, one-cycle tick.
// - Packet: shreg[8:0] = {par, din}, par = ~^din (odd parity). Bits leave LSB first.
// - FSM:
//   IDLE  : wr_ps2 -> load shreg, clear ack_err, ps2c_oe=1, cnt=0 -> RTS. wr_ps2 in any other state ignored.
//   RTS   : ps2c_oe=1; after exactly INHIBIT_CYCLES cycles: ps2d_oe=1 (start bit 0), ps2c_oe=0 same cycle -> START.
//   START : ps2d_oe=1; on fall #1: ps2d_oe=~shreg[0], shift, bitcnt=8 -> DATA.
//   DATA  : on each fall: ps2d_oe=~shreg[0], shift, bitcnt-1; fall #2..#9 output d1..d7,par. On fall with bitcnt=0
//           (fall #10): ps2d_oe=0 (stop=1) -> STOP.
//   STOP  : wait fall #11 -> ACK.
//   ACK   : first cycle after fall #11 sample synced ps2d: 0 = ack, 1 -> ack_err=1 -> WAIT.
//   WAIT  : wait synced ps2c=1 and ps2d=1 (device released) -> IDLE, tx_done_tick=1 that cycle.
// - ps2d_oe only changes on fall ticks (data changes while device clock low; device samples on rising edge).
// - Glitch on ps2c shorter than FILTER_LEN cycles: no fall tick, no bit advance.
// - Latency wr_ps2 -> ps2c_oe=1: 1 cycle. Outputs registered.
// CONFIGURATION
// PS2_TX_TIMEOUT_EN defined: watchdog counter cleared on entry to START and on every fall tick; in START/DATA/STOP/ACK/
//   WAIT reaching TIMEOUT_CYCLES -> both oe=0, ack_err=1, tx_done_tick=1, IDLE next cycle.
// PS2_TX_TIMEOUT_EN undefined: no watchdog; FSM waits indefinitely for device clocks; TIMEOUT_CYCLES unused.
// TESTING  (bench: INHIBIT_CYCLES=100, FILTER_LEN=8, clk 10 ns, device model ps2c period 1000 ns, samples on rise)
// 1 rst=0 for 10 cycles, mid-run -> ps2c_oe=ps2d_oe=0, tx_idle=1, tx_done_tick=0, ack_err=0.
// 2 wr_ps2 din=0xED -> ps2c_oe high exactly 100 cycles, then ps2d_oe=1; device captures start 0, bits 1,0,1,1,0,1,1,1,
//   parity 1, stop 1; device acks -> tx_done_tick one pulse after lines idle, ack_err=0, tx_idle=1.
// 3 din=0x01 -> parity 0; din=0xFF -> parity 1; din=0x00 -> parity 1; all captured frames match.
// 4 din=0xF4, device leaves ps2d high at clock 11 -> ack_err=1, tx_done_tick pulse; next wr_ps2 clears ack_err.
// 5 wr_ps2 din=0xAA during DATA -> ignored, frame still 0xED; 3-cycle low glitch on ps2c in DATA -> no extra bit;
//   rst=0 at fall #5 -> both oe 0 same cycle, no done tick, next wr_ps2 sends full frame.
// 6 PS2_TX_TIMEOUT_EN, TIMEOUT_CYCLES=5000, device never clocks -> 5000 cycles after START entry: oe both 0,
//   ack_err=1, tx_done_tick pulse; without macro FSM stays in START.

Source files
------------

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ps2_host_tx                                                     |
// | Purpose  : PS/2 host-to-device command transmitter (open-collector OEs).   |
// | Option   : PS2_TX_TIMEOUT_EN enables the device-clock watchdog.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RTS   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_ACK   = 3'd5;
  localparam logic [2:0] ST_WAIT  = 3'd6;

  localparam int CNT_W = $clog2(INHIBIT_CYCLES + 1);

  logic [1:0]            r_c_sync;
  logic [1:0]            r_d_sync;
  logic [FILTER_LEN-1:0] r_c_shift;
  logic                  r_c_filt;
  logic                  r_fall;

  logic [2:0]            r_state;
  logic [2:0]            w_state_nx;
  logic [8:0]            r_shreg;
  logic [8:0]            w_shreg_nx;
  logic [3:0]            r_bitcnt;
  logic [3:0]            w_bitcnt_nx;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nx;
  logic                  w_c_oe_nx;
  logic                  w_d_oe_nx;
  logic                  w_done_nx;
  logic                  w_err_nx;
  logic                  w_rts_last;
  logic                  w_released;
  logic                  w_timeout;

  // Idle bus is high, so the conditioning chain resets to 1 to avoid a spurious fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_sync  <= 2'b11;
      r_d_sync  <= 2'b11;
      r_c_shift <= '1;
      r_c_filt  <= 1'b1;
      r_fall    <= 1'b0;
    end else begin
      r_c_sync  <= {r_c_sync[0], ps2c_in};
      r_d_sync  <= {r_d_sync[0], ps2d_in};
      r_c_shift <= {r_c_shift[FILTER_LEN-2:0], r_c_sync[1]};
      r_fall    <= 1'b0;
      if (r_c_shift == '1) begin
        r_c_filt <= 1'b1;
      end else if (r_c_shift == '0) begin
        r_c_filt <= 1'b0;
        r_fall   <= r_c_filt;
      end
    end
  end

  assign w_rts_last = (r_cnt == CNT_W'(INHIBIT_CYCLES - 1));
  assign w_released = r_c_sync[1] & r_d_sync[1];

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wdog;
  logic            w_wd_active;

  assign w_wd_active = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP) ||
                       (r_state == ST_ACK)   || (r_state == ST_WAIT);

  // Held at zero until START, so the count starts fresh on START entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (!w_wd_active || r_fall) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_timeout = w_wd_active && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (wr_ps2) w_state_nx = ST_RTS;
      ST_RTS:   if (w_rts_last) w_state_nx = ST_START;
      ST_START: if (r_fall) w_state_nx = ST_DATA;
      ST_DATA:  if (r_fall && (r_bitcnt == 4'd0)) w_state_nx = ST_STOP;
      ST_STOP:  if (r_fall) w_state_nx = ST_ACK;
      ST_ACK:   w_state_nx = ST_WAIT;
      ST_WAIT:  if (w_released) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
    if (w_timeout) w_state_nx = ST_IDLE;
  end

  // Data line only changes on fall ticks, while the device holds its clock low.
  always_comb begin
    w_c_oe_nx   = ps2c_oe;
    w_d_oe_nx   = ps2d_oe;
    w_shreg_nx  = r_shreg;
    w_bitcnt_nx = r_bitcnt;
    w_cnt_nx    = r_cnt;
    w_done_nx   = 1'b0;
    w_err_nx    = ack_err;
    case (r_state)
      ST_IDLE: begin
        if (wr_ps2) begin
          w_shreg_nx = {~^din, din};
          w_err_nx   = 1'b0;
          w_c_oe_nx  = 1'b1;
          w_d_oe_nx  = 1'b0;
          w_cnt_nx   = '0;
        end
      end
      ST_RTS: begin
        w_cnt_nx = r_cnt + 1'b1;
        if (w_rts_last) begin
          w_c_oe_nx = 1'b0;
          w_d_oe_nx = 1'b1;
        end
      end
      ST_START: begin
        if (r_fall) begin
          w_d_oe_nx   = ~r_shreg[0];
          w_shreg_nx  = {1'b0, r_shreg[8:1]};
          w_bitcnt_nx = 4'd8;
        end
      end
      ST_DATA: begin
        if (r_fall) begin
          if (r_bitcnt == 4'd0) begin
            w_d_oe_nx = 1'b0;
          end else begin
            w_d_oe_nx   = ~r_shreg[0];
            w_shreg_nx  = {1'b0, r_shreg[8:1]};
            w_bitcnt_nx = r_bitcnt - 4'd1;
          end
        end
      end
      ST_STOP: begin
        w_d_oe_nx = 1'b0;
      end
      ST_ACK: begin
        if (r_d_sync[1]) w_err_nx = 1'b1;
      end
      ST_WAIT: begin
        if (w_released) w_done_nx = 1'b1;
      end
      default: begin
        w_c_oe_nx = 1'b0;
        w_d_oe_nx = 1'b0;
      end
    endcase
    if (w_timeout) begin
      w_c_oe_nx = 1'b0;
      w_d_oe_nx = 1'b0;
      w_err_nx  = 1'b1;
      w_done_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps2c_oe      <= 1'b0;
      ps2d_oe      <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      ack_err      <= 1'b0;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_cnt        <= '0;
    end else begin
      ps2c_oe      <= w_c_oe_nx;
      ps2d_oe      <= w_d_oe_nx;
      tx_idle      <= (w_state_nx == ST_IDLE);
      tx_done_tick <= w_done_nx;
      ack_err      <= w_err_nx;
      r_shreg      <= w_shreg_nx;
      r_bitcnt     <= w_bitcnt_nx;
      r_cnt        <= w_cnt_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ps2_host_tx                                                  |
// | Purpose  : Bench for ps2_host_tx with a behavioural PS/2 keyboard model.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_ps2_host_tx;

  localparam int INHIBIT = 100;

  typedef struct {
    logic [7:0]  din;
    bit          ack;
    logic [10:0] frame;
    bit          err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_ps2;
  logic [7:0] din;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err;
  logic       dev_c_low, dev_d_low, glitch;
  logic       c_line, d_line;

  int   n_vec    = 0;
  int   n_miss   = 0;
  int   done_cnt = 0;
  int   run_len  = 0;
  int   last_len = 0;
  logic d_at_rel = 1'b0;

  // Open-collector bus with pull-ups; device and host both only pull low.
  assign c_line = ~(ps2c_oe | dev_c_low | glitch);
  assign d_line = ~(ps2d_oe | dev_d_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c_in     (c_line),
    .ps2d_in     (d_line),
    .ps2c_oe     (ps2c_oe),
    .ps2d_oe     (ps2d_oe),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .ack_err     (ack_err)
  );

  always @(negedge clk) begin
    if (tx_done_tick) done_cnt++;
    if (ps2c_oe) begin
      run_len++;
    end else if (run_len != 0) begin
      last_len = run_len;
      d_at_rel = ps2d_oe;
      run_len  = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Host strobe followed by the keyboard side of one frame; cap[0]=start ... cap[10]=stop.
  task automatic frame(input logic [7:0] d, input bit do_ack, input int glitch_at,
                       input int intrude_at, input int abort_at,
                       output logic [10:0] cap, output bit ok);
    int t;
    cap = '0;
    ok  = 1'b1;
    @(negedge clk);
    din    = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    check("rts_latency", ps2c_oe, 1);
    check("busy_after_wr", tx_idle, 0);
    check("err_cleared_on_wr", ack_err, 0);
    t = 0;
    while (ps2c_oe && t < 2 * INHIBIT) begin
      @(negedge clk);
      t++;
    end
    if (ps2c_oe) begin
      ok = 1'b0;
      return;
    end
    #200;
    cap[0] = d_line;
    for (int i = 1; i <= 11; i++) begin
      if (i == glitch_at) begin
        #100; glitch = 1'b1; #30; glitch = 1'b0; #370;
      end else if (i == intrude_at) begin
        #100; din = 8'hAA; wr_ps2 = 1'b1; #10; wr_ps2 = 1'b0; #390;
      end else begin
        #500;
      end
      if (i == 11 && do_ack) dev_d_low = 1'b1;
      dev_c_low = 1'b1;
      if (i == abort_at) begin
        #200;
        return;
      end
      #500;
      dev_c_low = 1'b0;
      if (i <= 10) cap[i] = d_line;
    end
    #200;
    dev_d_low = 1'b0;
  endtask

  task automatic finish_frame(input string tag, input logic [10:0] cap, input bit ok,
                              input logic [10:0] exp_frame, input bit exp_err, input int done0);
    int t = 0;
    check($sformatf("%s_rts_released", tag), ok, 1);
    while (!tx_idle && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check($sformatf("%s_frame", tag), cap, exp_frame);
    check($sformatf("%s_ack_err", tag), ack_err, exp_err);
    check($sformatf("%s_done_pulses", tag), done_cnt - done0, 1);
    check($sformatf("%s_idle", tag), tx_idle, 1);
    check($sformatf("%s_rts_len", tag), last_len, INHIBIT);
    check($sformatf("%s_start_at_release", tag), d_at_rel, 1);
  endtask

  initial begin
    vec_t        vecs [6];
    logic [10:0] cap;
    bit          ok;
    int          done0;
    int          t;
    int          n;

    vecs[0] = '{din: 8'hED, ack: 1'b1, frame: 11'h7DA, err: 1'b0};
    vecs[1] = '{din: 8'h01, ack: 1'b1, frame: 11'h402, err: 1'b0};
    vecs[2] = '{din: 8'hFF, ack: 1'b1, frame: 11'h7FE, err: 1'b0};
    vecs[3] = '{din: 8'h00, ack: 1'b1, frame: 11'h600, err: 1'b0};
    vecs[4] = '{din: 8'hF4, ack: 1'b0, frame: 11'h5E8, err: 1'b1};
    vecs[5] = '{din: 8'hED, ack: 1'b1, frame: 11'h7DA, err: 1'b0};

    rst       = 1'b1;
    wr_ps2    = 1'b0;
    din       = 8'h00;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    glitch    = 1'b0;
    #2 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_c_oe", ps2c_oe, 0);
    check("reset_d_oe", ps2d_oe, 0);
    check("reset_idle", tx_idle, 1);
    check("reset_done", tx_done_tick, 0);
    check("reset_err", ack_err, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      done0 = done_cnt;
      frame(vecs[k].din, vecs[k].ack, 0, 0, 0, cap, ok);
      finish_frame($sformatf("vec%0d", k), cap, ok, vecs[k].frame, vecs[k].err, done0);
    end

    // Ignored strobe during DATA plus a short ps2c glitch before fall 4.
    done0 = done_cnt;
    frame(8'hED, 1'b1, 4, 6, 0, cap, ok);
    finish_frame("glitch_intrude", cap, ok, 11'h7DA, 1'b0, done0);

    // Async reset while the device holds clock 5 low (host is driving d4=0).
    done0 = done_cnt;
    frame(8'hED, 1'b1, 0, 0, 5, cap, ok);
    check("abort_pre_d_oe", ps2d_oe, 1);
    rst = 1'b0;
    #1;
    check("abort_c_oe", ps2c_oe, 0);
    check("abort_d_oe", ps2d_oe, 0);
    check("abort_idle", tx_idle, 1);
    dev_c_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - done0, 0);
    done0 = done_cnt;
    frame(8'hED, 1'b1, 0, 0, 0, cap, ok);
    finish_frame("after_abort", cap, ok, 11'h7DA, 1'b0, done0);

    // Device never clocks.
    done0 = done_cnt;
    @(negedge clk);
    din    = 8'h55;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    t = 0;
    while (ps2c_oe && t < 2 * INHIBIT) begin
      @(negedge clk);
      t++;
    end
    check("silent_rts_release", ps2c_oe, 0);
    n = 0;
`ifdef PS2_TX_TIMEOUT_EN
    while (ps2d_oe && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, 5000);
    check("timeout_done", tx_done_tick, 1);
    check("timeout_err", ack_err, 1);
    check("timeout_idle", tx_idle, 1);
`else
    repeat (6000) @(negedge clk);
    check("no_timeout_busy", tx_idle, 0);
    check("no_timeout_d_oe", ps2d_oe, 1);
    check("no_timeout_done", done_cnt - done0, 0);
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired, expected completion");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
